// File: rtl/onchip_arb_pkg.sv
// Shared defaults and types for the two-requester on-chip memory arbiter.
package onchip_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;
    localparam int BE_W       = DATA_W_DEF / 8;

    // Identifies one of the two requesters
    typedef logic port_id_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, remembers the last winner
// so that a tie always goes to the requester that did not win most recently.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);
    import onchip_arb_pkg::*;

    port_id_t last_grant_q;
    port_id_t last_grant_d;

    // Pick the winner this cycle; on a tie favour the port that lost last time
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant_q == PORT1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Only a cycle that actually moves a command changes the fairness history
    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = grant[1] ? PORT1 : PORT0;
        end
    end

    // Reset to "port 1 won last" so port 0 takes the first tie
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant_q <= PORT1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port on-chip RAM between two Avalon-style requesters.
// Reads return exactly one cycle after acceptance; writes complete on acceptance.
module onchip_mem_arbiter #(
    parameter int ADDR_W = onchip_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = onchip_arb_pkg::DATA_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   s0_address,
    input  logic                s0_read,
    input  logic                s0_write,
    input  logic [DATA_W/8-1:0] s0_byteenable,
    input  logic [DATA_W-1:0]   s0_writedata,
    output logic                s0_waitrequest,
    output logic [DATA_W-1:0]   s0_readdata,
    output logic                s0_readdatavalid,
    output logic [CNT_W-1:0]    s0_grant_cnt,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic                s1_waitrequest,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic [CNT_W-1:0]    s1_grant_cnt,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);
    import onchip_arb_pkg::*;

    logic [1:0]  req;
    logic [1:0]  grant;
    logic        accept;
    port_id_t    sel;
    logic        sel_write;
    logic        pend_valid_q, pend_valid_d;
    port_id_t    pend_id_q, pend_id_d;
    logic [1:0][CNT_W-1:0] cnt_out;

    // Requests are masked while in reset so nothing can be granted
    assign req    = {s1_read | s1_write, s0_read | s0_write} & {2{reset_n}};
    assign accept = |grant;
    assign sel    = grant[1] ? PORT1 : PORT0;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .accept  (accept),
        .grant   (grant)
    );

    // Command mux: idle cycles fall through to requester 0's signals
    always_comb begin
        mem_address    = s0_address;
        mem_byteenable = s0_byteenable;
        mem_writedata  = s0_writedata;
        sel_write      = s0_write;
        if (sel == PORT1) begin
            mem_address    = s1_address;
            mem_byteenable = s1_byteenable;
            mem_writedata  = s1_writedata;
            sel_write      = s1_write;
        end
    end

    assign mem_chipselect = accept;
    assign mem_write      = accept & sel_write;
    assign mem_clken      = reset_n;
    assign s0_waitrequest = ~grant[0];
    assign s1_waitrequest = ~grant[1];

    // A read+write collision counts as a write, so it returns no data
    always_comb begin
        pend_valid_d = accept & ~sel_write;
        pend_id_d    = sel;
    end

    // Single pending-read slot is enough because RAM latency is one cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_valid_q <= 1'b0;
            pend_id_q    <= PORT0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_id_q    <= pend_id_d;
        end
    end

    // Gate with reset_n so a read accepted just before reset never responds
    assign s0_readdatavalid = reset_n & pend_valid_q & (pend_id_q == PORT0);
    assign s1_readdatavalid = reset_n & pend_valid_q & (pend_id_q == PORT1);
    assign s0_readdata      = mem_readdata;
    assign s1_readdata      = mem_readdata;

    // Per-port saturating count of accepted commands
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // Stop at all-ones instead of wrapping
        always_comb begin
            cnt_d = cnt_q;
            if (grant[gi] && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Counter register
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt_out[gi] = cnt_q;
    end

    assign s0_grant_cnt = cnt_out[0];
    assign s1_grant_cnt = cnt_out[1];

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Randomised + directed bench for onchip_mem_arbiter against a transaction-level model.
module tb_onchip_mem_arbiter;

    localparam int AW      = 12;
    localparam int DW      = 32;
    localparam int BW      = DW / 8;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] a;
        logic [BW-1:0] be;
        logic [DW-1:0] wd;
    } port_in_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [AW-1:0] s0_address, s1_address;
    logic          s0_read, s0_write, s1_read, s1_write;
    logic [BW-1:0] s0_byteenable, s1_byteenable;
    logic [DW-1:0] s0_writedata, s1_writedata;
    logic          s0_waitrequest, s1_waitrequest;
    logic [DW-1:0] s0_readdata, s1_readdata;
    logic          s0_readdatavalid, s1_readdatavalid;
    logic [CW-1:0] s0_grant_cnt, s1_grant_cnt;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_byteenable;
    logic [DW-1:0] mem_writedata;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [DW-1:0] mem_readdata;

    onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .s0_address       (s0_address),
        .s0_read          (s0_read),
        .s0_write         (s0_write),
        .s0_byteenable    (s0_byteenable),
        .s0_writedata     (s0_writedata),
        .s0_waitrequest   (s0_waitrequest),
        .s0_readdata      (s0_readdata),
        .s0_readdatavalid (s0_readdatavalid),
        .s0_grant_cnt     (s0_grant_cnt),
        .s1_address       (s1_address),
        .s1_read          (s1_read),
        .s1_write         (s1_write),
        .s1_byteenable    (s1_byteenable),
        .s1_writedata     (s1_writedata),
        .s1_waitrequest   (s1_waitrequest),
        .s1_readdata      (s1_readdata),
        .s1_readdatavalid (s1_readdatavalid),
        .s1_grant_cnt     (s1_grant_cnt),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_writedata    (mem_writedata),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] wd, logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BW; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // Single-port RAM with registered address, unregistered output
    logic [DW-1:0] ram [4096];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
            ram_q <= ram[mem_address];
        end
    end
    assign mem_readdata = ram_q;

    // Reference model state
    logic [DW-1:0] shadow [4096];
    bit            known [4096];
    int            m_last = 1;
    int            m_pend = -1;
    logic [DW-1:0] m_pend_data;
    bit            m_pend_known;
    int            m_cnt [2];
    bit            m_cnt_known = 0;

    port_in_t nx [2];
    logic     nx_rst_n;

    // Values seen in the most recent step, for directed checks
    logic          obs_s0_wait, obs_s1_wait, obs_s0_rdv, obs_s1_rdv, obs_mem_write;
    logic [DW-1:0] obs_s0_rd, obs_s1_rd;
    logic [CW-1:0] obs_s0_cnt, obs_s1_cnt;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic set_port(int p, logic rd, logic wr, logic [AW-1:0] a, logic [BW-1:0] be, logic [DW-1:0] wd);
        nx[p].rd = rd; nx[p].wr = wr; nx[p].a = a; nx[p].be = be; nx[p].wd = wd;
    endtask

    task automatic idle_all();
        set_port(0, 0, 0, '0, '0, '0);
        set_port(1, 0, 0, '0, '0, '0);
    endtask

    // One clock cycle: apply staged inputs, compare every output, advance the model
    task automatic step();
        int  w;
        bit  r0, r1;
        @(negedge clk);
        reset_n       = nx_rst_n;
        s0_read       = nx[0].rd; s0_write = nx[0].wr; s0_address = nx[0].a;
        s0_byteenable = nx[0].be; s0_writedata = nx[0].wd;
        s1_read       = nx[1].rd; s1_write = nx[1].wr; s1_address = nx[1].a;
        s1_byteenable = nx[1].be; s1_writedata = nx[1].wd;
        #1;
        r0 = reset_n && (nx[0].rd || nx[0].wr);
        r1 = reset_n && (nx[1].rd || nx[1].wr);
        if (r0 && r1)  w = (m_last == 0) ? 1 : 0;
        else if (r0)   w = 0;
        else if (r1)   w = 1;
        else           w = -1;

        check_eq("s0_waitrequest", s0_waitrequest, (w == 0) ? 0 : 1);
        check_eq("s1_waitrequest", s1_waitrequest, (w == 1) ? 0 : 1);
        check_eq("mem_chipselect", mem_chipselect, (w >= 0) ? 1 : 0);
        check_eq("mem_clken", mem_clken, reset_n);
        if (w >= 0) begin
            check_eq("mem_write", mem_write, nx[w].wr);
            check_eq("mem_address", mem_address, nx[w].a);
            check_eq("mem_byteenable", mem_byteenable, nx[w].be);
            check_eq("mem_writedata", mem_writedata, nx[w].wd);
        end else begin
            check_eq("mem_write_idle", mem_write, 0);
            check_eq("mem_address_idle", mem_address, nx[0].a);
        end
        check_eq("s0_readdatavalid", s0_readdatavalid, (reset_n && m_pend == 0) ? 1 : 0);
        check_eq("s1_readdatavalid", s1_readdatavalid, (reset_n && m_pend == 1) ? 1 : 0);
        if (reset_n && m_pend_known) begin
            if (m_pend == 0) check_eq("s0_readdata", s0_readdata, m_pend_data);
            if (m_pend == 1) check_eq("s1_readdata", s1_readdata, m_pend_data);
        end
        if (m_cnt_known) begin
            check_eq("s0_grant_cnt", s0_grant_cnt, m_cnt[0]);
            check_eq("s1_grant_cnt", s1_grant_cnt, m_cnt[1]);
        end

        obs_s0_wait = s0_waitrequest; obs_s1_wait = s1_waitrequest;
        obs_s0_rdv  = s0_readdatavalid; obs_s1_rdv = s1_readdatavalid;
        obs_s0_rd   = s0_readdata; obs_s1_rd = s1_readdata;
        obs_s0_cnt  = s0_grant_cnt; obs_s1_cnt = s1_grant_cnt;
        obs_mem_write = mem_write;

        if (!reset_n) begin
            m_last = 1; m_pend = -1; m_cnt[0] = 0; m_cnt[1] = 0; m_cnt_known = 1;
        end else begin
            m_pend = -1;
            m_pend_known = 0;
            if (w >= 0) begin
                m_last = w;
                if (m_cnt[w] < CNT_MAX) m_cnt[w] = m_cnt[w] + 1;
                if (nx[w].wr) begin
                    shadow[nx[w].a] = merge(shadow[nx[w].a], nx[w].wd, nx[w].be);
                    known[nx[w].a]  = 1;
                    $display("txn t=%0t s%0d write a=0x%03h be=0x%0h d=0x%08h", $time, w, nx[w].a, nx[w].be, nx[w].wd);
                end else begin
                    m_pend       = w;
                    m_pend_data  = shadow[nx[w].a];
                    m_pend_known = known[nx[w].a];
                    $display("txn t=%0t s%0d read  a=0x%03h exp=0x%08h", $time, w, nx[w].a, m_pend_data);
                end
            end
        end
    endtask

    initial begin
        idle_all();
        nx_rst_n = 1'b0;
        repeat (3) step();
        nx_rst_n = 1'b1;

        // Both read continuously: alternate grants, responses one cycle later
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                set_port(0, 1, 0, 12'h020, 4'hF, '0);
                set_port(1, 1, 0, 12'h021, 4'hF, '0);
            end else begin
                idle_all();
            end
            step();
            if (i < 4) check_eq("rr_s0_grant", obs_s0_wait, (i % 2 == 0) ? 0 : 1);
            check_eq("rr_s0_rdv", obs_s0_rdv, (i == 1 || i == 3) ? 1 : 0);
            check_eq("rr_s1_rdv", obs_s1_rdv, (i == 2 || i == 4) ? 1 : 0);
        end

        // Write on one port, read back on the other
        idle_all(); set_port(0, 0, 1, 12'h123, 4'hF, 32'hDEADBEEF); step();
        idle_all(); set_port(1, 1, 0, 12'h123, 4'hF, '0); step();
        idle_all(); step();
        check_eq("xport_rdv", obs_s1_rdv, 1);
        check_eq("xport_data", obs_s1_rd, 32'hDEADBEEF);

        // Partial byte-lane write
        idle_all(); set_port(0, 0, 1, 12'h010, 4'hF, 32'h11223344); step();
        idle_all(); set_port(1, 0, 1, 12'h010, 4'h1, 32'h000000AA); step();
        idle_all(); set_port(1, 1, 0, 12'h010, 4'hF, '0); step();
        idle_all(); step();
        check_eq("be_merge", obs_s1_rd, 32'h112233AA);

        // Read and write together is a write with no response
        idle_all(); set_port(0, 1, 1, 12'h004, 4'hF, 32'hCAFEF00D); step();
        check_eq("rdwr_memwrite", obs_mem_write, 1);
        idle_all(); step();
        check_eq("rdwr_no_rdv", obs_s0_rdv, 0);
        idle_all(); set_port(0, 1, 0, 12'h004, 4'hF, '0); step();
        idle_all(); step();
        check_eq("rdwr_data", obs_s0_rd, 32'hCAFEF00D);

        // Read accepted right before reset must not respond
        idle_all(); set_port(0, 1, 0, 12'h123, 4'hF, '0); step();
        idle_all(); nx_rst_n = 1'b0; step();
        check_eq("rst_no_rdv", obs_s0_rdv, 0);
        nx_rst_n = 1'b1; step();
        check_eq("rst_no_rdv_after", obs_s0_rdv, 0);
        check_eq("rst_cnt0", obs_s0_cnt, 0);
        check_eq("rst_cnt1", obs_s1_cnt, 0);
        set_port(0, 1, 0, 12'h010, 4'hF, '0);
        set_port(1, 1, 0, 12'h123, 4'hF, '0);
        step();
        check_eq("rst_tie_s0", obs_s0_wait, 0);
        check_eq("rst_tie_s1", obs_s1_wait, 1);
        idle_all(); step();

        // Seed a small address window, then random traffic with occasional resets
        for (int i = 0; i < 16; i++) begin
            idle_all(); set_port(0, 0, 1, AW'(i), 4'hF, $urandom); step();
        end
        for (int i = 0; i < 2000; i++) begin
            for (int p = 0; p < 2; p++) begin
                int op;
                op = $urandom_range(0, 3);
                set_port(p, op[0], op[1], AW'($urandom_range(0, 15)), BW'($urandom), $urandom);
            end
            nx_rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            step();
        end
        nx_rst_n = 1'b1;

        // Counter saturation
        idle_all(); nx_rst_n = 1'b0; step(); nx_rst_n = 1'b1;
        for (int i = 0; i < CNT_MAX - 1; i++) begin
            set_port(0, 0, 1, 12'h030, 4'hF, i); step();
        end
        idle_all(); step();
        check_eq("sat_pre", obs_s0_cnt, CNT_MAX - 1);
        for (int i = 0; i < 3; i++) begin
            set_port(0, 0, 1, 12'h030, 4'hF, i); step();
        end
        idle_all(); step();
        check_eq("sat_hold", obs_s0_cnt, CNT_MAX);
        check_eq("sat_other", obs_s1_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/onchip_mem_arbiter.md
ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, memory word-address width (4096 x 32-bit words).
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width DATA_W/8.
REQ-003 SHALL have parameter CNT_W, default 16, width of the per-port grant counters.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset_n  in  1  reset, synchronous and active-low.
REQ-006 sN_address  in  ADDR_W  word address, requester N (N = 0, 1).
REQ-007 sN_read / sN_write  in  1  read / write request, requester N.
REQ-008 sN_byteenable  in  DATA_W/8  byte lanes, requester N.
REQ-009 sN_writedata  in  DATA_W  write data, requester N.
REQ-010 sN_waitrequest  out  1  high = command not accepted this cycle.
REQ-011 sN_readdata  out  DATA_W  read data, requester N.
REQ-012 sN_readdatavalid  out  1  sN_readdata valid this cycle.
REQ-013 sN_grant_cnt  out  CNT_W  saturating count of accepted commands, requester N.
REQ-014 mem_address / mem_byteenable / mem_writedata  out  ADDR_W / DATA_W/8 / DATA_W  memory command.
REQ-015 mem_chipselect / mem_write / mem_clken  out  1  memory select, write strobe, clock enable.
REQ-016 mem_readdata  in  DATA_W  unregistered single-port RAM output.

Function
REQ-017 Requester N requests in a cycle iff sN_read | sN_write; if both are high, the command SHALL be treated as a write and no read data returned.
REQ-018 Grant SHALL be combinational each cycle: single requester wins; if both request, the one not granted most recently (last_grant register) wins.
REQ-019 last_grant SHALL update only on a cycle with an accepted command.
REQ-020 Granted requester SHALL see waitrequest = 0; a requester not granted SHALL see waitrequest = 1; an idle requester SHALL see waitrequest = 1.
REQ-021 In an accepted cycle, mem_chipselect = 1, and mem_write, mem_address, mem_byteenable and mem_writedata SHALL equal the granted requester's signals.
REQ-022 With no accepted command: mem_chipselect = 0, mem_write = 0; other mem outputs are don't-care but SHALL be driven from requester 0.
REQ-023 Accepted read SHALL produce sN_readdatavalid = 1 exactly one cycle later on the granted port only, with sN_readdata = mem_readdata; one pending-read register of {valid, id}.
REQ-024 Back-to-back reads, on one port or alternating ports, SHALL sustain one read per cycle with no bubble.
REQ-025 Writes SHALL complete on acceptance; no response.
REQ-026 sN_readdata SHALL be mem_readdata unconditionally; it is meaningful only with readdatavalid.
REQ-027 mem_clken SHALL be 1 whenever reset_n = 1.
REQ-028 sN_grant_cnt SHALL increment by 1 per accepted command and saturate at 2^CNT_W-1 without wrapping.

Reset
REQ-029 With reset_n = 0 sampled at a clk edge: last_grant := 1 (requester 0 wins the first tie), pending-read valid := 0, grant counters := 0.
REQ-030 While reset_n = 0: both waitrequest = 1, mem_chipselect = 0, mem_write = 0, mem_clken = 0, readdatavalid = 0.
REQ-031 A read accepted in the cycle before reset asserts SHALL NOT produce readdatavalid.

Structure
REQ-032 Package onchip_arb_pkg SHALL hold ADDR_W/DATA_W defaults, BE_W, and a 1-bit port-id type.
REQ-033 The two-way round-robin grant logic with last_grant SHALL be sub-module rr_arb2 (req[1:0], accept in; grant[1:0] out).

Verification
REQ-034 s0 and s1 both read continuously for 4 cycles after reset -> grants s0,s1,s0,s1, with s0_readdatavalid in cycles 2 and 4 and s1_readdatavalid in cycles 3 and 5.
REQ-035 s0 writes 0xDEADBEEF to 0x123 with byteenable 0xF, then s1 reads 0x123 -> s1_readdata = 0xDEADBEEF one cycle after acceptance.
REQ-036 s1 writes 0x000000AA to 0x010 with byteenable 0x1 over a prior 0x11223344 -> a read of 0x010 returns 0x112233AA.
REQ-037 s0 asserts read and write together at 0x004 -> memory write occurs, no s0_readdatavalid.
REQ-038 s0 read accepted, reset_n low next cycle -> no readdatavalid; after release, both grant counters = 0 and the first tie goes to s0.
REQ-039 Force s0_grant_cnt to 0xFFFE, then issue 3 accepted commands -> the counter holds 0xFFFF.
